// File: rtl/keypad_scan_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, idle/reset
// line patterns and the row priority encoder used to form key codes.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] ROW_IDLE  = 4'b1111;
  localparam logic [3:0] COL_RESET = 4'b1110;

  // Lowest-numbered low row wins when several rows are pressed together.
  function automatic logic [1:0] low_row(input logic [3:0] rows);
    logic [1:0] idx;
    idx = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; resets to
// all-ones so an unpressed keypad is seen during and right after reset.
module key_sync #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces
// presses and releases over sample points, and pulses key_valid per new key.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int SCAN_DIV = 4,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] keypad_in,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [MW-1:0] DB_N     = MW'(DEBOUNCE);
  localparam logic [MW:0]   DB_W     = (MW+1)'(DEBOUNCE);

  logic [3:0]    rs;
  logic [3:0]    lat_rows;
  logic [1:0]    col_idx;
  logic [1:0]    lat_col;
  logic [DW-1:0] dwell;
  logic [MW-1:0] match;
  logic [MW-1:0] rel;
  logic [MW:0]   rel_nxt;
  logic          sample;
  state_t        state;

  key_sync #(.W(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row),
    .q   (rs)
  );

  assign sample  = (dwell == DIV_LAST);
  assign rel_nxt = {1'b0, rel} + (MW+1)'(1);

  // Free-running dwell counter; sample points stay on a fixed grid in all states.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        dwell <= '0;
    else if (sample) dwell <= '0;
    else             dwell <= dwell + DW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_SCAN;
      col       <= COL_RESET;
      col_idx   <= 2'd0;
      lat_col   <= 2'd0;
      lat_rows  <= ROW_IDLE;
      match     <= '0;
      rel       <= '0;
      keypad_in <= 4'h0;
      key_valid <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      case (state)
        ST_SCAN: begin
          if (sample) begin
            if (rs == ROW_IDLE) begin
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
            end else begin
              lat_col  <= col_idx;
              lat_rows <= rs;
              match    <= '0;
              state    <= ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          // Acceptance takes the cycle after the final matching sample.
          if (match == DB_N) begin
            keypad_in <= {low_row(lat_rows), lat_col};
            key_valid <= 1'b1;
            state     <= ST_HELD;
          end else if (sample) begin
            if (rs == lat_rows) begin
              match <= match + MW'(1);
            end else begin
              state   <= ST_SCAN;
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
            end
          end
        end
        ST_HELD: begin
          if (sample && rs == ROW_IDLE) begin
            rel   <= MW'(1);
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (sample) begin
            if (rs != ROW_IDLE) begin
              state <= ST_HELD;
            end else if (rel_nxt >= DB_W) begin
              state   <= ST_SCAN;
              col     <= {col[2:0], col[3]};
              col_idx <= col_idx + 2'd1;
            end else begin
              rel <= rel + MW'(1);
            end
          end
        end
        default: state <= ST_SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan (SCAN_DIV=4, DEBOUNCE=3) driving a 4x4
// switch-matrix model; each vector holds a key set for N clocks then checks.
module tb_keypad_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  keypad_in;
  logic        key_valid;
  logic [15:0] keys = '0;   // bit r*4+c = key at row r, column c held down

  int nchk  = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  // A pressed switch pulls its row low only while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  keypad_scan #(.SCAN_DIV(4), .DEBOUNCE(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .row       (row),
    .col       (col),
    .keypad_in (keypad_in),
    .key_valid (key_valid)
  );

  typedef struct {
    logic [15:0] keys;
    int          cycles;
    logic [3:0]  col;
    logic [3:0]  code;
    int          pulses;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic run(input logic [15:0] k, input int n, output int p);
    keys = k;
    p = 0;
    repeat (n) begin
      @(posedge clk);
      #1;
      if (key_valid) p++;
    end
  endtask

  initial begin
    int p;
    //             keys      cyc  col      code  pulses   edge count after
    vecs[0]  = '{16'h0000,   4, 4'b1101, 4'd0, 0};  // 4   idle rotation
    vecs[1]  = '{16'h0000,   4, 4'b1011, 4'd0, 0};  // 8
    vecs[2]  = '{16'h0000,   4, 4'b0111, 4'd0, 0};  // 12
    vecs[3]  = '{16'h0000,  28, 4'b1011, 4'd0, 0};  // 40
    vecs[4]  = '{16'h0040,  16, 4'b1011, 4'd0, 0};  // 56  key 6, detect at 44
    vecs[5]  = '{16'h0040,   1, 4'b1011, 4'd6, 1};  // 57  pulse 13 after detect
    vecs[6]  = '{16'h0040,  83, 4'b1011, 4'd6, 0};  // 140 held, col frozen
    vecs[7]  = '{16'h0000,   4, 4'b1011, 4'd6, 0};  // 144 one idle sample
    vecs[8]  = '{16'h0040,  20, 4'b1011, 4'd6, 0};  // 164 back to held
    vecs[9]  = '{16'h0000,  12, 4'b0111, 4'd6, 0};  // 176 full release
    vecs[10] = '{16'h0008,  17, 4'b0111, 4'd3, 1};  // 193 key 3
    vecs[11] = '{16'h0000,  11, 4'b1110, 4'd3, 0};  // 204
    vecs[12] = '{16'h0001,   4, 4'b1110, 4'd3, 0};  // 208 bounce: one sample
    vecs[13] = '{16'h0000,   4, 4'b1101, 4'd3, 0};  // 212 resumes next column
    vecs[14] = '{16'h0000,  20, 4'b1011, 4'd3, 0};  // 232
    vecs[15] = '{16'h2002,  29, 4'b1101, 4'd1, 1};  // 261 rows 0+3 in col 1
    vecs[16] = '{16'h0000,  11, 4'b1011, 4'd1, 0};  // 272
    vecs[17] = '{16'h0400,   6, 4'b1011, 4'd1, 0};  // 278 key 10 debouncing

    repeat (2) @(posedge clk);
    #1;
    check("reset col", int'(col), int'(4'b1110));
    check("reset keypad_in", int'(keypad_in), 0);
    check("reset key_valid", int'(key_valid), 0);
    rst = 1'b1;

    for (int i = 0; i < 18; i++) begin
      run(vecs[i].keys, vecs[i].cycles, p);
      check($sformatf("v%0d col", i), int'(col), int'(vecs[i].col));
      check($sformatf("v%0d keypad_in", i), int'(keypad_in), int'(vecs[i].code));
      check($sformatf("v%0d pulses", i), p, vecs[i].pulses);
    end

    // Reset mid-debounce: outputs clear without waiting for a clock edge.
    #2 rst = 1'b0;
    #1;
    check("abort col", int'(col), int'(4'b1110));
    check("abort keypad_in", int'(keypad_in), 0);
    check("abort key_valid", int'(key_valid), 0);
    keys = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    check("restart col", int'(col), int'(4'b1110));
    run(16'h0000, 4, p);
    check("restart col step", int'(col), int'(4'b1101));
    check("restart pulses", p, 0);
    run(16'h0000, 16, p);
    check("post-abort pulses", p, 0);
    check("post-abort keypad_in", int'(keypad_in), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nfail);
    $finish;
  end

endmodule
